// File: rtl/periph_pkg.sv
// Shared types and helpers for the peripheral-to-FT601 TX packetizer.
package periph_pkg;

  localparam int NUM_PERIPH = 8;
  localparam int PERIPH_W   = 3;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HEADER,
    PAYLOAD,
    DONE
  } state_t;

  // Header layout: sync byte, 5 zero bits, peripheral id, 16-bit payload length.
  function automatic logic [WORD_W-1:0] make_header(input logic [7:0]          sync,
                                                    input logic [PERIPH_W-1:0] id,
                                                    input logic [15:0]         len);
    return {sync, 5'b0, id, len};
  endfunction

endpackage

// File: rtl/periph_tx_packetizer_burst_buffer.sv
// Register array holding one burst of payload words: one write port, asynchronous read.
module burst_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/periph_tx_packetizer.sv
// Drains up to MAX_BURST words from the granted RX FIFO and emits them as one
// header-prefixed packet on a valid/ready stream toward the FT601 TX path.
module periph_tx_packetizer
  import periph_pkg::*;
#(
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PERIPH_W-1:0]          grant,
  input  logic [NUM_PERIPH-1:0]        rx_fifo_empty,
  input  logic [NUM_PERIPH*WORD_W-1:0] rx_fifo_rdata,
  output logic [NUM_PERIPH-1:0]        rx_fifo_rd_en,
  output logic                         read_periph_data,
  output logic [WORD_W-1:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam int               IDX_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t              state;
  logic [PERIPH_W-1:0] sel;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic                sel_empty;
  logic [WORD_W-1:0]   sel_rdata;
  logic [WORD_W-1:0]   buf_rdata;
  logic                pop;
  logic                last_word;

  assign sel_empty = rx_fifo_empty[sel];
  assign sel_rdata = rx_fifo_rdata[sel*WORD_W +: WORD_W];
  assign pop       = (state == COLLECT) && !sel_empty && (cnt < CNT_MAX);
  assign last_word = (CNT_W'(idx) == cnt - CNT_W'(1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_fifo_rd_en = '0;
    if (pop) rx_fifo_rd_en[sel] = 1'b1;
  end

  // Stream outputs decode only the state registers, so nothing depends on tx_ready.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = make_header(SYNC_BYTE, sel, 16'(cnt));
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = buf_rdata;
      end
      default: ;
    endcase
  end

  assign read_periph_data = (state == DONE);
  assign busy             = (state != IDLE);

  burst_buffer #(
    .DEPTH (MAX_BURST),
    .WIDTH (WORD_W),
    .AW    (IDX_W)
  ) u_burst_buffer (
    .clk   (clk),
    .we    (pop),
    .waddr (cnt[IDX_W-1:0]),
    .wdata (sel_rdata),
    .raddr (idx),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_fifo_empty[grant]) begin
            sel   <= grant;
            cnt   <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          // No pop means either the burst is full or the FIFO ran dry.
          if (pop)              cnt   <= cnt + CNT_W'(1);
          else if (cnt == '0)   state <= IDLE;
          else                  state <= HEADER;
        end
        HEADER: begin
          if (tx_ready) begin
            idx   <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (tx_ready) begin
            if (last_word) state <= DONE;
            else           idx   <= idx + IDX_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_tx_packetizer.sv
// Directed bench for periph_tx_packetizer with a show-ahead FIFO model per peripheral.
module tb_periph_tx_packetizer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   grant = 3'd0;
  logic [7:0]   rx_fifo_empty = 8'hFF;
  logic [255:0] rx_fifo_rdata = '0;
  logic [7:0]   rx_fifo_rd_en;
  logic         read_periph_data;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  periph_tx_packetizer #(.MAX_BURST(16), .SYNC_BYTE(8'hA5)) dut (
    .clk              (clk),
    .rst              (rst),
    .grant            (grant),
    .rx_fifo_empty    (rx_fifo_empty),
    .rx_fifo_rdata    (rx_fifo_rdata),
    .rx_fifo_rd_en    (rx_fifo_rd_en),
    .read_periph_data (read_periph_data),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: pops on rd_en at the edge, flags update like flops.
  logic [31:0] fq [8][$];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rx_fifo_rd_en[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      rx_fifo_empty[i]         <= (fq[i].size() == 0);
      rx_fifo_rdata[32*i +: 32] <= (fq[i].size() == 0) ? 32'h0 : fq[i][0];
    end
  end

  // Stream monitor sampled mid-cycle; inputs change only just after posedge.
  logic [31:0] got [$];
  int          cyc = 0, last_hs_cyc = 0, rpd_cyc = 0, busy_cyc = 0, valid_cyc = 0;
  int          rpd_cnt = 0, stab_err = 0;
  int          rd_cnt [8] = '{default: 0};
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        last_hs_cyc = cyc;
      end
      if (read_periph_data) begin
        rpd_cnt++;
        rpd_cyc = cyc;
      end
      for (int i = 0; i < 8; i++) if (rx_fifo_rd_en[i]) rd_cnt[i]++;
      if (busy && !prev_busy)      busy_cyc  = cyc;
      if (tx_valid && !prev_valid) valid_cyc = cyc;
      if (prev_valid && !prev_ready && (!tx_valid || tx_data !== prev_data)) stab_err++;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_busy  = busy;
    end
  end

  task automatic wait_rpd(input int target, input int budget);
    int n = 0;
    while (rpd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (rpd_cnt < target) begin
      miscompares++;
      $display("FAIL wait_rpd: read_periph_data count %0d, required %0d within %0d cycles",
               rpd_cnt, target, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({tx_valid, busy, read_periph_data, rx_fifo_rd_en, tx_data} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b busy=%b rpd=%b rd_en=%h data=%h, required all 0",
               tx_valid, busy, read_periph_data, rx_fifo_rd_en, tx_data);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic [31:0] exp [2] = '{32'hA503_0001, 32'hDEAD_BEEF};
    int base = rpd_cnt;
    int rd3  = rd_cnt[3];
    got.delete();
    grant    = 3'd3;
    tx_ready = 1'b1;
    fq[3].push_back(32'hDEAD_BEEF);
    wait_rpd(base + 1, 50);
    repeat (5) @(negedge clk);
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL single_len: got %0d words, required 2", got.size());
    end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL single_word%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (rpd_cnt != base + 1) begin
      miscompares++;
      $display("FAIL single_rpd_count: got %0d pulses, required 1", rpd_cnt - base);
    end
    vectors++;
    if (rpd_cyc != last_hs_cyc + 1) begin
      miscompares++;
      $display("FAIL single_rpd_timing: pulse %0d cycles after last handshake, required 1",
               rpd_cyc - last_hs_cyc);
    end
    vectors++;
    if (valid_cyc - busy_cyc != 2) begin
      miscompares++;
      $display("FAIL single_latency: header %0d cycles after leaving IDLE, required 2",
               valid_cyc - busy_cyc);
    end
    vectors++;
    if (rd_cnt[3] - rd3 != 1) begin
      miscompares++;
      $display("FAIL single_rd_en: got %0d pops, required 1", rd_cnt[3] - rd3);
    end
  endtask

  task automatic test_full_burst;
    logic [31:0] exp [$];
    int base = rpd_cnt;
    int rd0  = rd_cnt[0];
    got.delete();
    exp.push_back(32'hA500_0010);
    for (int i = 0; i < 16; i++) exp.push_back(32'(i));
    exp.push_back(32'hA500_0004);
    for (int i = 16; i < 20; i++) exp.push_back(32'(i));
    @(posedge clk);
    #1;
    grant = 3'd0;
    for (int i = 0; i < 20; i++) fq[0].push_back(32'(i));
    wait_rpd(base + 1, 200);
    vectors++;
    if (rd_cnt[0] - rd0 != 16) begin
      miscompares++;
      $display("FAIL burst_pops1: got %0d pops, required 16", rd_cnt[0] - rd0);
    end
    wait_rpd(base + 2, 200);
    vectors++;
    if (rd_cnt[0] - rd0 != 20) begin
      miscompares++;
      $display("FAIL burst_pops2: got %0d pops in packet 2, required 4", rd_cnt[0] - rd0 - 16);
    end
    vectors++;
    if (got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL burst_len: got %0d words, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL burst_word%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [$];
    int base = rpd_cnt;
    int n    = 0;
    got.delete();
    stab_err = 0;
    exp.push_back(32'hA501_0007);
    for (int i = 0; i < 7; i++) exp.push_back(32'h1100_0000 + 32'(i * 3));
    @(posedge clk);
    #1;
    grant = 3'd1;
    for (int i = 1; i < 8; i++) fq[1].push_back(exp[i]);
    while (rpd_cnt < base + 1 && n < 400) begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(0, 9) < 3);
      n++;
    end
    tx_ready = 1'b1;
    vectors++;
    if (rpd_cnt < base + 1) begin
      miscompares++;
      $display("FAIL bp_timeout: packet not completed within 400 cycles");
    end
    vectors++;
    if (stab_err != 0) begin
      miscompares++;
      $display("FAIL bp_stable: %0d stall cycles changed valid/data, required 0", stab_err);
    end
    vectors++;
    if (got.size() != 8) begin
      miscompares++;
      $display("FAIL bp_len: got %0d words, required 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL bp_word%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_grant_change;
    logic [31:0] exp [$] = '{32'hA502_0003, 32'h2222_0000, 32'h2222_0001, 32'h2222_0002,
                              32'hA506_0002, 32'h6666_0000, 32'h6666_0001};
    int base = rpd_cnt;
    int rd2  = rd_cnt[2];
    int rd6  = rd_cnt[6];
    int n    = 0;
    got.delete();
    @(posedge clk);
    #1;
    grant = 3'd2;
    for (int i = 0; i < 3; i++) fq[2].push_back(32'h2222_0000 + 32'(i));
    for (int i = 0; i < 2; i++) fq[6].push_back(32'h6666_0000 + 32'(i));
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    grant = 3'd6;
    wait_rpd(base + 1, 100);
    vectors++;
    if (rd_cnt[6] != rd6 || fq[6].size() != 2) begin
      miscompares++;
      $display("FAIL gc_fifo6: %0d pops, %0d left; required 0 pops, 2 left",
               rd_cnt[6] - rd6, fq[6].size());
    end
    vectors++;
    if (rd_cnt[2] - rd2 != 3) begin
      miscompares++;
      $display("FAIL gc_fifo2: got %0d pops, required 3", rd_cnt[2] - rd2);
    end
    wait_rpd(base + 2, 100);
    vectors++;
    if (got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL gc_len: got %0d words, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL gc_word%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp [2] = '{32'hA505_0001, 32'h5555_00DD};
    int base;
    int n = 0;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    grant    = 3'd5;
    fq[5].push_back(32'h5555_00AA);
    fq[5].push_back(32'h5555_00BB);
    fq[5].push_back(32'h5555_00CC);
    while (!tx_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    vectors++;
    if (!tx_valid || tx_data !== 32'h5555_00AA) begin
      miscompares++;
      $display("FAIL rst_payload: valid=%b data=%h, required valid=1 data=555500aa",
               tx_valid, tx_data);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({tx_valid, busy, read_periph_data, rx_fifo_rd_en, tx_data} !== 43'd0) begin
      miscompares++;
      $display("FAIL rst_async: valid=%b busy=%b rpd=%b rd_en=%h data=%h, required all 0",
               tx_valid, busy, read_periph_data, rx_fifo_rd_en, tx_data);
    end
    fq[5].push_back(32'h5555_00DD);
    repeat (3) @(posedge clk);
    #1;
    got.delete();
    base     = rpd_cnt;
    rst      = 1'b1;
    tx_ready = 1'b1;
    wait_rpd(base + 1, 50);
    repeat (4) @(negedge clk);
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL rst_after_len: got %0d words, required 2", got.size());
    end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rst_after_word%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_starvation;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      grant = 3'(c);
      @(negedge clk);
      vectors++;
      if (busy || tx_valid || read_periph_data || rx_fifo_rd_en != 8'h00) begin
        miscompares++;
        $display("FAIL starve_c%0d: busy=%b valid=%b rpd=%b rd_en=%h, required all 0",
                 c, busy, tx_valid, read_periph_data, rx_fifo_rd_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_burst();
    test_backpressure();
    test_grant_change();
    test_reset_mid();
    test_starvation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
